// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with a direct mode and a
// prescaled auto-scan mode.
//
// Parameters:
//   W        - select-code width (1..6); dout is 2**W bits wide.
//   PRESCALE - clock cycles per scan step (1..255).
//
// Build option:
//   SCAN_DECODER_ACTIVE_LOW_EN - when defined, dout is one-cold: every bit
//   is inverted, so dout is all ones in OFF and during reset. idx, wrap and
//   the state machine behave identically in both builds.
//
// Every output is a flop. The incoming en/mode pick the state that the next
// edge enters, and that edge already produces the new state's outputs.
module scan_decoder #(
    parameter int W        = 3,
    parameter int PRESCALE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [W-1:0]       sel,
    input  logic               load,
    input  logic               dir,
    output logic [(2**W)-1:0]  dout,
    output logic [W-1:0]       idx,
    output logic               wrap
);

    localparam int N = 2 ** W;

    localparam logic [W-1:0] IDX_MAX  = {W{1'b1}};
    localparam logic [7:0]   PRE_LAST = 8'(PRESCALE - 1);

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
    localparam logic [N-1:0] POL = '1;
`else
    localparam logic [N-1:0] POL = '0;
`endif

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DIRECT,
        ST_SCAN
    } state_t;

    state_t       state_q;
    state_t       nxt_state;
    logic [7:0]   pre_q;
    logic [7:0]   nxt_pre;
    logic [W-1:0] nxt_idx;
    logic         nxt_wrap;
    logic [N-1:0] nxt_dout;

    function automatic logic [N-1:0] onehot(input logic [W-1:0] v);
        logic [N-1:0] r;
        r    = '0;
        r[v] = 1'b1;
        return r;
    endfunction

    // Next state and next output values, chosen by the state being entered.
    always_comb begin
        nxt_state = ST_OFF;
        nxt_idx   = idx;
        nxt_pre   = '0;
        nxt_wrap  = 1'b0;
        nxt_dout  = POL;

        if (en) begin
            nxt_state = mode ? ST_SCAN : ST_DIRECT;
        end

        case (nxt_state)
            ST_OFF: begin
                nxt_dout = POL;
            end
            ST_DIRECT: begin
                nxt_idx  = sel;
                nxt_dout = onehot(sel) ^ POL;
            end
            ST_SCAN: begin
                if (load) begin
                    nxt_idx = sel;
                end else if (state_q == ST_SCAN) begin
                    if (pre_q == PRE_LAST) begin
                        if (dir) begin
                            nxt_idx  = idx + 1'b1;
                            nxt_wrap = (idx == IDX_MAX);
                        end else begin
                            nxt_idx  = idx - 1'b1;
                            nxt_wrap = (idx == '0);
                        end
                    end else begin
                        nxt_pre = pre_q + 8'd1;
                    end
                end
                nxt_dout = onehot(nxt_idx) ^ POL;
            end
            default: begin
                nxt_dout = POL;
            end
        endcase
    end

    // State and output registers; reset forces OFF with a cleared count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            pre_q   <= '0;
            idx     <= '0;
            wrap    <= 1'b0;
            dout    <= POL;
        end else begin
            state_q <= nxt_state;
            pre_q   <= nxt_pre;
            idx     <= nxt_idx;
            wrap    <= nxt_wrap;
            dout    <= nxt_dout;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed bench for scan_decoder (W=3). Instance dut uses
// PRESCALE=4, instance dut1 uses PRESCALE=1; both share the same inputs.
// Honours SCAN_DECODER_ACTIVE_LOW_EN so expected dout values flip with it.
module tb_scan_decoder;

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
    localparam logic [7:0] POL = 8'hFF;
`else
    localparam logic [7:0] POL = 8'h00;
`endif

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [2:0] sel;
    logic       load;
    logic       dir;

    logic [7:0] dout;
    logic [2:0] idx;
    logic       wrap;
    logic [7:0] dout1;
    logic [2:0] idx1;
    logic       wrap1;

    int n_compared;
    int n_mismatched;

    scan_decoder #(.W(3), .PRESCALE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .load  (load),
        .dir   (dir),
        .dout  (dout),
        .idx   (idx),
        .wrap  (wrap)
    );

    scan_decoder #(.W(3), .PRESCALE(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .load  (load),
        .dir   (dir),
        .dout  (dout1),
        .idx   (idx1),
        .wrap  (wrap1)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive a new input vector, then wait one rising edge and settle 1 time unit.
    task automatic applyStimulus(input logic e, input logic m, input logic [2:0] s,
                                 input logic l, input logic d);
        en   = e;
        mode = m;
        sel  = s;
        load = l;
        dir  = d;
        @(posedge clk);
        #1;
    endtask

    // Let n edges pass with the inputs unchanged.
    task automatic waitEdges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        sel   = 3'd0;
        load  = 1'b0;
        dir   = 1'b0;

        // Reset state before any clock edge.
        #3;
        checkOutput("rst_idx",  8'(idx),  8'd0);
        checkOutput("rst_dout", dout,     POL);
        checkOutput("rst_wrap", 8'(wrap), 8'd0);
        #1 rst_n = 1'b1;

        // Direct decode.
        applyStimulus(1, 0, 3'd5, 0, 0);
        checkOutput("dir5_idx",  8'(idx), 8'd5);
        checkOutput("dir5_dout", dout,    8'b0010_0000 ^ POL);
        applyStimulus(1, 0, 3'd0, 0, 0);
        checkOutput("dir0_idx",  8'(idx), 8'd0);
        checkOutput("dir0_dout", dout,    8'b0000_0001 ^ POL);
        applyStimulus(1, 0, 3'd2, 1, 1);
        checkOutput("dir_load_ignored", 8'(idx), 8'd2);
        checkOutput("dir_wrap", 8'(wrap), 8'd0);
        applyStimulus(1, 0, 3'd6, 0, 0);
        checkOutput("dir6_idx", 8'(idx), 8'd6);

        // Scan up from 6 with PRESCALE=4.
        applyStimulus(1, 1, 3'd0, 0, 1);
        checkOutput("scan_entry_idx",  8'(idx), 8'd6);
        checkOutput("scan_entry_dout", dout,    8'b0100_0000 ^ POL);
        waitEdges(3);
        checkOutput("scan_hold_idx", 8'(idx), 8'd6);
        waitEdges(1);
        checkOutput("scan_step_idx",  8'(idx),  8'd7);
        checkOutput("scan_step_wrap", 8'(wrap), 8'd0);
        waitEdges(3);
        checkOutput("scan_hold7_idx", 8'(idx), 8'd7);
        waitEdges(1);
        checkOutput("wrap_up_idx",  8'(idx),  8'd0);
        checkOutput("wrap_up_wrap", 8'(wrap), 8'd1);
        checkOutput("wrap_up_dout", dout,     8'b0000_0001 ^ POL);
        waitEdges(1);
        checkOutput("wrap_up_clear", 8'(wrap), 8'd0);

        // Load on the terminal prescaler cycle beats the step.
        waitEdges(2);
        applyStimulus(1, 1, 3'd3, 1, 1);
        checkOutput("load_idx",  8'(idx),  8'd3);
        checkOutput("load_wrap", 8'(wrap), 8'd0);
        checkOutput("load_dout", dout,     8'b0000_1000 ^ POL);
        applyStimulus(1, 1, 3'd0, 0, 1);
        waitEdges(2);
        checkOutput("load_hold_idx", 8'(idx), 8'd3);
        waitEdges(1);
        checkOutput("load_next_step", 8'(idx), 8'd4);

        // Direction change mid-count keeps the count; step uses current dir.
        applyStimulus(1, 1, 3'd0, 0, 0);
        applyStimulus(1, 1, 3'd0, 0, 0);
        applyStimulus(1, 1, 3'd0, 0, 1);
        checkOutput("dirchg_hold_idx", 8'(idx), 8'd4);
        applyStimulus(1, 1, 3'd0, 0, 0);
        checkOutput("dirchg_step_idx", 8'(idx), 8'd3);

        // Disable mid-scan, then resume from the held index.
        applyStimulus(1, 1, 3'd0, 0, 1);
        applyStimulus(0, 1, 3'd0, 0, 1);
        checkOutput("off_dout", dout,    POL);
        checkOutput("off_idx",  8'(idx), 8'd3);
        waitEdges(1);
        checkOutput("off_idx_held", 8'(idx), 8'd3);
        applyStimulus(1, 1, 3'd0, 0, 1);
        checkOutput("resume_dout", dout, 8'b0000_1000 ^ POL);
        waitEdges(3);
        checkOutput("resume_hold_idx", 8'(idx), 8'd3);
        waitEdges(1);
        checkOutput("resume_step_idx", 8'(idx), 8'd4);

        // SCAN -> DIRECT mid-count abandons the count.
        waitEdges(2);
        applyStimulus(1, 0, 3'd1, 0, 1);
        checkOutput("abandon_idx",  8'(idx),  8'd1);
        checkOutput("abandon_wrap", 8'(wrap), 8'd0);
        applyStimulus(1, 1, 3'd0, 0, 1);
        waitEdges(3);
        checkOutput("abandon_hold_idx", 8'(idx), 8'd1);
        waitEdges(1);
        checkOutput("abandon_step_idx", 8'(idx), 8'd2);

        // Asynchronous reset between edges, mid-scan, with dir=0 for dut1.
        applyStimulus(1, 1, 3'd0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_idx",  8'(idx),  8'd0);
        checkOutput("async_rst_dout", dout,     POL);
        checkOutput("async_rst_wrap", 8'(wrap), 8'd0);
        checkOutput("async_rst_idx1", 8'(idx1), 8'd0);
        #1 rst_n = 1'b1;

        // PRESCALE=1 scanning down from 0.
        applyStimulus(1, 1, 3'd0, 0, 0);
        checkOutput("p1_entry_idx",  8'(idx1),  8'd0);
        checkOutput("p1_entry_wrap", 8'(wrap1), 8'd0);
        waitEdges(1);
        checkOutput("p1_wrap_idx",  8'(idx1),  8'd7);
        checkOutput("p1_wrap_wrap", 8'(wrap1), 8'd1);
        checkOutput("p1_wrap_dout", dout1,     8'b1000_0000 ^ POL);
        waitEdges(1);
        checkOutput("p1_next_idx",  8'(idx1),  8'd6);
        checkOutput("p1_next_wrap", 8'(wrap1), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter W, default 3, select-code width; output width is 2**W; legal range 1..6.
REQ-002 Parameter PRESCALE, default 4, clock cycles per scan step; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 en  input  1  block enable; 0 forces the OFF state.
REQ-006 mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-007 sel  input  W  code to decode in direct mode; load value in scan mode.
REQ-008 load  input  1  scan mode: load sel into the index on this cycle.
REQ-009 dir  input  1  scan direction; 1 = increment, 0 = decrement.
REQ-010 dout  output  2**W  registered one-hot decode of idx; all zeros when OFF.
REQ-011 idx  output  W  registered current index.
REQ-012 wrap  output  1  one-cycle pulse on a scan wrap-around.

Function
REQ-013 The FSM SHALL have three states: OFF, DIRECT and SCAN, which are re-evaluated every cycle from en and mode.
REQ-014 Transitions: en=0 -> OFF; en=1 with mode=0 -> DIRECT; en=1 with mode=1 -> SCAN; a transition SHALL take effect on the next edge.
REQ-015 OFF: dout SHALL be all zeros, idx SHALL hold its value, the prescaler SHALL be cleared, and wrap SHALL be 0.
REQ-016 DIRECT: idx SHALL be updated to sel and dout to onehot(sel) with 1-cycle latency; the prescaler SHALL be cleared and wrap SHALL be 0; load and dir SHALL be ignored.
REQ-017 SCAN entry: idx SHALL be retained from the prior state, and the prescaler SHALL start at 0 on the first SCAN cycle.
REQ-018 SCAN: the prescaler SHALL count 0..PRESCALE-1; on the cycle it equals PRESCALE-1, idx SHALL step by +1 (dir=1) or -1 (dir=0) modulo 2**W, and the prescaler SHALL return to 0.
REQ-019 With PRESCALE=1, idx SHALL step every SCAN cycle.
REQ-020 Wrap: wrap SHALL pulse for exactly one cycle, aligned with the new idx, when idx steps from 2**W-1 to 0 (up) or from 0 to 2**W-1 (down).
REQ-021 load=1 in SCAN SHALL set idx to sel and clear the prescaler, SHALL take priority over a coincident step, and SHALL NOT raise wrap.
REQ-022 A change of dir mid-count SHALL NOT clear the prescaler; the next step SHALL use the dir value sampled on the step cycle.
REQ-023 In DIRECT and SCAN, dout SHALL always equal onehot(idx); in every state, exactly one bit or zero bits of dout SHALL be set.
REQ-024 A change of mode from SCAN to DIRECT mid-count SHALL abandon the count, with no step and no wrap.
REQ-025 All outputs SHALL be driven from flops, with no combinational path from inputs to outputs.

Reset
REQ-026 rst_n=0 SHALL immediately force state=OFF, idx=0, dout=0, wrap=0 and prescaler=0, independent of clk.
REQ-027 Reset deassertion SHALL take effect at the first rising clk edge after rst_n rises; reset asserted mid-scan SHALL discard the count with no wrap pulse.

Configuration
REQ-028 Macro SCAN_DECODER_ACTIVE_LOW_EN SHALL control the output polarity of dout.
REQ-029 With the macro defined: dout SHALL be bitwise inverted (one-cold), and all ones in OFF and in reset.
REQ-030 Without the macro: dout SHALL be one-hot as specified above; idx, wrap and the FSM SHALL be unaffected in either build.

Verification
REQ-031 Reset then en=1, mode=0, sel=5 (W=3) -> next edge: idx=5, dout=8'b0010_0000; sel=0 -> next edge: dout=8'b0000_0001.
REQ-032 W=3, PRESCALE=4, SCAN, dir=1, starting at idx=6 -> idx=7 after 4 cycles, idx=0 after 8 cycles with wrap=1 for that cycle only.
REQ-033 PRESCALE=1, SCAN, dir=0, idx=0 -> next edge: idx=7, wrap=1; following edge: idx=6, wrap=0.
REQ-034 SCAN with load=1, sel=3 on the cycle the prescaler equals PRESCALE-1 -> idx=3, no step, wrap=0, next step 4 cycles later.
REQ-035 Mid-scan en=0 -> dout=0 with idx held; en=1, mode=1 -> scanning resumes from the held idx after PRESCALE cycles.
REQ-036 rst_n pulled low between clock edges mid-scan -> dout=0 and idx=0 immediately; rerun REQ-031 with SCAN_DECODER_ACTIVE_LOW_EN defined -> dout=8'b1101_1111.
